// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front end.
package button_pkg;

  localparam int MS_PER_S = 1000;

  // One channel's registered outputs. "release" is a keyword, hence release_p.
  typedef struct packed {
    logic level;
    logic press;
    logic release_p;
    logic long_p;
    logic repeat_p;
  } btn_evt_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / MS_PER_S) * ms;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debouncer, edge pulses and, with
// BTN_AUTOREPEAT_EN defined, long-press / auto-repeat generation.
module btn_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int LONG_CYCLES = 10,
  parameter int REP_CYCLES  = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     btn,
  output btn_evt_t evt
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_db_err
    $error("btn_channel: debounce window must be at least 2 cycles");
  end
  if (SYNC_STAGES < 2) begin : g_sync_err
    $error("btn_channel: synchroniser needs at least 2 stages");
  end
  if (LONG_CYCLES < 1 || REP_CYCLES < 1) begin : g_hold_err
    $error("btn_channel: long-press and repeat periods must be positive");
  end

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [DB_W-1:0]        db_cnt_reg;
  logic                   level_reg;
  logic                   press_reg;
  logic                   release_reg;
  logic                   long_reg;
  logic                   repeat_reg;
  logic                   sync;
  logic                   accept;

  assign sync   = sync_reg[SYNC_STAGES-1];
  // The mismatch has lasted DB_CYCLES clocks including this one.
  assign accept = (sync != level_reg) && (db_cnt_reg == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg    <= '0;
      db_cnt_reg  <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], btn};
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (sync == level_reg) begin
        db_cnt_reg <= '0;
      end else if (!accept) begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end else begin
        level_reg   <= sync;
        db_cnt_reg  <= '0;
        press_reg   <= sync;
        release_reg <= ~sync;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REP_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [REP_W-1:0]  rep_cnt_reg;
  logic              long_done_reg;

  // Any accepted edge (press or release) restarts the hold timing; release wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_reg  <= '0;
      rep_cnt_reg   <= '0;
      long_done_reg <= 1'b0;
      long_reg      <= 1'b0;
      repeat_reg    <= 1'b0;
    end else begin
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;
      if (accept || !level_reg) begin
        hold_cnt_reg  <= '0;
        rep_cnt_reg   <= '0;
        long_done_reg <= 1'b0;
      end else if (!long_done_reg) begin
        if (hold_cnt_reg == HOLD_LAST) begin
          long_reg      <= 1'b1;
          repeat_reg    <= 1'b1;
          long_done_reg <= 1'b1;
          rep_cnt_reg   <= '0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end
      end else if (rep_cnt_reg == REP_LAST) begin
        repeat_reg  <= 1'b1;
        rep_cnt_reg <= '0;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
      end
    end
  end
`else
  assign long_reg   = 1'b0;
  assign repeat_reg = 1'b0;
`endif

  assign evt = {level_reg, press_reg, release_reg, long_reg, repeat_reg};

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: polarity normalisation plus one btn_channel
// per input. Long-press/auto-repeat is built only with BTN_AUTOREPEAT_EN defined.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_LOW    = 0,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_btn,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_long,
  output logic [NUM_CH-1:0] o_repeat
);

  localparam int DB_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int REP_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_MS);

  if (NUM_CH < 1) begin : g_ch_err
    $error("button_conditioner: at least one channel is required");
  end

  // Everything behind this point works in the pressed = 1 domain.
  logic [NUM_CH-1:0] btn_norm;
  assign btn_norm = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  btn_evt_t evt [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .REP_CYCLES  (REP_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_norm[gi]),
      .evt   (evt[gi])
    );

    assign o_level[gi]   = evt[gi].level;
    assign o_press[gi]   = evt[gi].press;
    assign o_release[gi] = evt[gi].release_p;
    assign o_long[gi]    = evt[gi].long_p;
    assign o_repeat[gi]  = evt[gi].repeat_p;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: an active-high and an active-low instance share one queue of
// expected output events, derived from the input timing.
module tb_button_conditioner;

  localparam int CLK_HZ  = 1000;
  localparam int DB_MS   = 4;
  localparam int SYNC    = 2;
  localparam int LONG_MS = 10;
  localparam int REP_MS  = 3;
  localparam int CPM     = CLK_HZ / 1000;
  localparam int LAT     = SYNC + DB_MS * CPM;
  localparam int LONG_C  = LONG_MS * CPM;
  localparam int REP_C   = REP_MS * CPM;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [1:0] btn_inv;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

  assign btn_inv = ~btn;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner #(
    .NUM_CH(2), .CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_MS(DB_MS), .SYNC_STAGES(SYNC),
    .ACTIVE_LOW(0), .LONG_PRESS_MS(LONG_MS), .REPEAT_MS(REP_MS)
  ) dut_a (
    .clk(clk), .reset(reset), .i_btn(btn),
    .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a), .o_long(lng_a), .o_repeat(rep_a)
  );

  button_conditioner #(
    .NUM_CH(2), .CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_MS(DB_MS), .SYNC_STAGES(SYNC),
    .ACTIVE_LOW(1), .LONG_PRESS_MS(LONG_MS), .REPEAT_MS(REP_MS)
  ) dut_b (
    .clk(clk), .reset(reset), .i_btn(btn_inv),
    .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b), .o_long(lng_b), .o_repeat(rep_b)
  );

  typedef struct {
    int         cyc;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] rep;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, act, exp, cyc);
  endtask

  task automatic push_evt(input int c, input logic [1:0] l, input logic [1:0] p,
                          input logic [1:0] r, input logic [1:0] lg, input logic [1:0] rp);
    exp_t e;
    e.cyc = c; e.level = l; e.press = p; e.rel = r; e.lng = lg; e.rep = rp;
    sb.push_back(e);
  endtask

  // Press accepted at cycle p, release accepted at cycle r.
  task automatic push_hold(input logic [1:0] mask, input int p, input int r);
    push_evt(p, mask, mask, 2'b00, 2'b00, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = p + LONG_C; t < r; t += REP_C)
      push_evt(t, mask, 2'b00, 2'b00, (t == p + LONG_C) ? mask : 2'b00, mask);
`endif
    push_evt(r, 2'b00, 2'b00, mask, 2'b00, 2'b00);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_a"}, {22'd0, lvl_a, prs_a, rel_a, lng_a, rep_a}, 32'd0);
    check_eq({tag, "_b"}, {22'd0, lvl_b, prs_b, rel_b, lng_b, rep_b}, 32'd0);
  endtask

  // Monitor: every cycle with any pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (|{prs_a, rel_a, lng_a, rep_a, prs_b, rel_b, lng_b, rep_b}) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_evt", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        $display("evt cyc=%0d exp_cyc=%0d lvl=%b/%b prs=%b/%b rel=%b/%b lng=%b/%b rep=%b/%b",
                 cyc, e.cyc, lvl_a, lvl_b, prs_a, prs_b, rel_a, rel_b, lng_a, lng_b, rep_a, rep_b);
        check_eq("evt_cyc",   cyc,   e.cyc);
        check_eq("level_a",   lvl_a, e.level);
        check_eq("press_a",   prs_a, e.press);
        check_eq("release_a", rel_a, e.rel);
        check_eq("long_a",    lng_a, e.lng);
        check_eq("repeat_a",  rep_a, e.rep);
        check_eq("level_b",   lvl_b, e.level);
        check_eq("press_b",   prs_b, e.press);
        check_eq("release_b", rel_b, e.rel);
        check_eq("long_b",    lng_b, e.lng);
        check_eq("repeat_b",  rep_b, e.rep);
      end
    end
  end

  initial begin
    int c;
    int d;
    reset = 1'b1;
    btn   = 2'b00;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Clean press on ch0, held long enough for long-press and repeats;
    // release lands on what would be the next repeat clock.
    c = cyc;
    btn = 2'b01;
    push_hold(2'b01, c + LAT, c + LAT + 31);
    wait_until(c + 31);
    btn = 2'b00;
    wait_until(c + 50);

    // Three-clock glitch: ignored.
    c = cyc;
    btn = 2'b01;
    wait_until(c + 3);
    btn = 2'b00;
    wait_until(c + 15);
    check_idle("glitch3");

    // Four-clock pulse: one press then one release.
    c = cyc;
    btn = 2'b01;
    push_hold(2'b01, c + LAT, c + 4 + LAT);
    wait_until(c + 4);
    btn = 2'b00;
    wait_until(c + 20);

    // Bounce every 2 clks for 12 clks, then steady high.
    c = cyc;
    push_hold(2'b01, c + 12 + LAT, c + 20 + LAT);
    for (int k = 0; k <= 6; k++) begin
      wait_until(c + 2 * k);
      btn = (k % 2 == 0) ? 2'b01 : 2'b00;
    end
    wait_until(c + 20);
    btn = 2'b00;
    wait_until(c + 40);

    // Both channels pressed and released in the same clock.
    c = cyc;
    btn = 2'b11;
    push_hold(2'b11, c + LAT, c + 8 + LAT);
    wait_until(c + 8);
    btn = 2'b00;
    wait_until(c + 25);

    // Reset while ch1 is pressed and ch0 has db_cnt = 3.
    c = cyc;
    btn = 2'b10;
    push_evt(c + LAT, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    wait_until(c + 8);
    d = cyc;
    btn = 2'b11;
    wait_until(d + 5);
    reset = 1'b1;
    wait_until(d + 6);
    check_idle("mid_reset");
    reset = 1'b0;
    push_hold(2'b11, d + 6 + LAT, d + 14 + LAT);
    wait_until(d + 14);
    btn = 2'b00;
    wait_until(d + 35);
    check_idle("final_idle");

    check_eq("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
